instruction_fetch_unit: RTL and testbench

Requester side of the instruction memory interface. Owns the program counter, drives a byte address to the combinational instruction ROM and captures the returned word together with its PC. Buffers fetched words in a small FIFO and presents them to decode with a valid/ready handshake. Supports pipeline stall, halt, and branch/jump redirect with flush.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instruction_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side constants and the fetch FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ILEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INCR  = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding {pc, instr} fetch entries; flush empties it in one cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 2 * XLEN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign pop_ok  = pop_i & (count_q != '0);
  assign push_ok = push_i & ((count_q < CW'(DEPTH)) | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, boot/fetch/halt FSM, redirect/flush, decode-side fetch buffer.
// Optional build macro IFU_MISALIGN_TRAP_EN adds a sticky misaligned-redirect trap.
module instruction_fetch_unit #(
  parameter int unsigned      XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC   = XLEN'(riscv_pkg::RESET_PC),
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_instr_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
  input  logic            ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            busy_o
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic            misalign_o,
  output logic [XLEN-1:0] fault_addr_o
`endif
);

  import riscv_pkg::fetch_state_e;
  import riscv_pkg::S_BOOT;
  import riscv_pkg::S_FETCH;
  import riscv_pkg::S_HALT;
  import riscv_pkg::PC_INCR;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              push, pop, flush;
  logic              redir_active, redir_ok;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [2*XLEN-1:0] fifo_rdata;

`ifdef IFU_MISALIGN_TRAP_EN
  logic              misalign_q, misalign_d;
  logic [XLEN-1:0]   fault_addr_q, fault_addr_d;
`endif

  // Redirect is ignored during the boot cycle; a misaligned target is rejected when trapping.
  assign redir_active = redirect_i & (state_q != S_BOOT);
`ifdef IFU_MISALIGN_TRAP_EN
  assign redir_ok = redir_active & (redirect_pc_i[1:0] == 2'b00);
`else
  assign redir_ok = redir_active;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      busy_q       <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
      fault_addr_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      busy_q       <= busy_d;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
      fault_addr_q <= fault_addr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: begin
        if (redir_ok)          state_d = S_FETCH;
        else if (redir_active) state_d = S_HALT;
        else if (halt_i)       state_d = S_HALT;
      end
      S_HALT:  if (redir_ok) state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    flush  = redir_active;
    pop    = ~fifo_empty & ready_i & ~redir_active;
    push   = (state_q == S_FETCH) & ~halt_i & ~redirect_i &
             ((fifo_count < CW'(FIFO_DEPTH)) | pop);
    pc_d   = pc_q;
    if (redir_ok)  pc_d = redirect_pc_i & ~XLEN'(3);
    else if (push) pc_d = pc_q + XLEN'(PC_INCR);
    busy_d = (state_d == S_FETCH);
`ifdef IFU_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
    fault_addr_d = fault_addr_q;
    if (redir_active & ~redir_ok) begin
      misalign_d   = 1'b1;
      fault_addr_d = redirect_pc_i;
    end
`endif
  end

  fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (2 * XLEN)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  ({pc_q, imem_instr_i}),
    .data_o  (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign imem_addr_o = pc_q;
  assign valid_o     = ~fifo_empty;
  assign pc_o        = fifo_rdata[2*XLEN-1:XLEN];
  assign instr_o     = fifo_rdata[XLEN-1:0];
  assign busy_o      = busy_q;
`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign_o   = misalign_q;
  assign fault_addr_o = fault_addr_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus queues expected PCs, a monitor checks accepted words.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] imem_addr_o, imem_instr_i, instr_o, pc_o, redirect_pc_i;
  logic        valid_o, ready_i, redirect_i, halt_i, busy_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .busy_o        (busy_o)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   rom = 32'h0040_2103;
      32'h4:   rom = 32'h0020_2423;
      default: rom = 32'h0000_0013 ^ (a << 8);
    endcase
  endfunction

  always_comb imem_instr_i = rom(imem_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every word decode accepts must be the next expected PC with its ROM word.
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i && !redirect_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word actual_pc=%h required=none", pc_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pc_o !== e || instr_o !== rom(e)) begin
          failures++;
          $display("FAIL accepted_word actual_pc=%h actual_instr=%h required_pc=%h required_instr=%h",
                   pc_o, instr_o, e, rom(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0;
    step(2);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);

    exp_q.push_back(32'h0);
    rst_i = 1'b0;
    step(1);
    chk("boot_valid", 32'(valid_o), 32'd0);
    chk("boot_busy", 32'(busy_o), 32'd1);
    chk("boot_addr", imem_addr_o, 32'h0);
    step(1);
    chk("first_valid", 32'(valid_o), 32'd1);
    chk("first_instr", instr_o, 32'h0040_2103);
    chk("first_pc", pc_o, 32'h0);
    chk("first_addr", imem_addr_o, 32'h4);
    step(1);
    chk("second_instr", instr_o, 32'h0020_2423);
    chk("second_pc", pc_o, 32'h4);

    // Decode stalls: buffer fills and PC stops.
    ready_i = 1'b0;
    step(3);
    chk("stall_addr", imem_addr_o, 32'hC);
    chk("stall_valid", 32'(valid_o), 32'd1);

    // Full buffer with decode ready: one word per cycle in order.
    foreach (exp_q[i]) begin end
    exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h10);
    ready_i = 1'b1;
    step(4);
    chk("thru_addr", imem_addr_o, 32'h1C);

    // Redirect while full; ready is ignored and stale words vanish.
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step(1);
    chk("redir_valid", 32'(valid_o), 32'd0);
    chk("redir_addr", imem_addr_o, 32'h40);
    redirect_i = 1'b0; ready_i = 1'b0;
    step(1);
    chk("redir_first_pc", pc_o, 32'h40);
    step(2);

    // Halt with two buffered: both drain, PC frozen.
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    halt_i = 1'b1; ready_i = 1'b1;
    step(3);
    chk("halt_valid", 32'(valid_o), 32'd0);
    chk("halt_busy", 32'(busy_o), 32'd0);
    chk("halt_addr", imem_addr_o, 32'h48);

    exp_q.push_back(32'h10); exp_q.push_back(32'h14); exp_q.push_back(32'h18);
    redirect_i = 1'b1; redirect_pc_i = 32'h10; halt_i = 1'b0;
    step(1);
    chk("resume_busy", 32'(busy_o), 32'd1);
    chk("resume_addr", imem_addr_o, 32'h10);
    redirect_i = 1'b0;
    step(4);
    chk("pre_rst_valid", 32'(valid_o), 32'd1);

    // Asynchronous reset mid-stream.
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid_o), 32'd0);
    chk("async_rst_addr", imem_addr_o, 32'h0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    step(1);
    ready_i = 1'b0;
    rst_i = 1'b0;
    step(1);

    // Misaligned redirect target has its low bits dropped.
    redirect_i = 1'b1; redirect_pc_i = 32'h6;
    step(1);
    chk("misalign_addr", imem_addr_o, 32'h4);
    chk("misalign_valid", 32'(valid_o), 32'd0);
    exp_q.push_back(32'h4);
    redirect_i = 1'b0; ready_i = 1'b1;
    step(2);
    ready_i = 1'b0;
    step(2);
    chk("restart_hold_pc", pc_o, 32'h8);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
